// File: rtl/apb_prefetch_unit_if.sv
// APB bus bundle used on the instruction-memory side of the prefetcher.
interface apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_prefetch_unit.sv
// Sequential APB instruction prefetcher feeding a DEPTH-entry {pc, inst, err} FIFO.
// A redirect flushes the FIFO and restarts fetching; an in-flight transfer is drained and dropped.
module apb_prefetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  apb_if.master                      imem_apb,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_target_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                inst_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_paddr;
  logic          r_psel;
  logic          r_penable;
  logic          r_discard;
  logic          r_halted;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic          r_err_mem  [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_done;
  logic          w_push;
  logic          w_pop;
  logic          w_halted_next;
  logic          w_launch;
  logic [CW-1:0] w_count_next;
  logic [31:0]   w_target;
  logic [31:0]   w_fetch_pc_next;
  logic          w_unused_lsbs;

  // The launch test uses post-edge occupancy, so the in-flight word always has a slot reserved.
  // A redirect empties the FIFO and clears halt, so it always launches toward the new target.
  always_comb begin
    w_done   = (r_state == S_ACCESS) && imem_apb.pready;
    w_push   = w_done && !r_discard && !redirect_i;
    w_pop    = valid_o && ready_i && !redirect_i;
    w_target = {redirect_target_i[31:2], 2'b00};

    w_count_next = r_count;
    if (redirect_i)
      w_count_next = '0;
    else if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - CW'(1);

    w_fetch_pc_next = r_fetch_pc;
    if (redirect_i)
      w_fetch_pc_next = w_target;
    else if (w_push)
      w_fetch_pc_next = r_fetch_pc + 32'd4;

    w_halted_next = redirect_i ? 1'b0 : (r_halted || (w_push && imem_apb.pslverr));
    w_launch      = !w_halted_next && (w_count_next < CW'(DEPTH));
  end

  assign w_unused_lsbs = ^redirect_target_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_paddr    <= '0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_discard  <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_halted   <= w_halted_next;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state   <= S_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= w_fetch_pc_next;
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
          if (redirect_i)
            r_discard <= 1'b1;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_discard <= 1'b0;
            if (w_launch) begin
              r_state   <= S_SETUP;
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_paddr   <= w_fetch_pc_next;
            end else begin
              r_state   <= S_IDLE;
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
            end
          end else if (redirect_i) begin
            r_discard <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (redirect_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_paddr;
      r_inst_mem[r_wr_ptr] <= imem_apb.prdata;
      r_err_mem[r_wr_ptr]  <= imem_apb.pslverr;
    end
  end

  assign valid_o = (r_count != '0);
  assign pc_o    = valid_o ? r_pc_mem[r_rd_ptr]   : 32'h0;
  assign inst_o  = valid_o ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign err_o   = valid_o ? r_err_mem[r_rd_ptr]  : 1'b0;
  assign count_o = r_count;

  assign imem_apb.psel    = r_psel;
  assign imem_apb.penable = r_penable;
  assign imem_apb.pwrite  = 1'b0;
  assign imem_apb.paddr   = r_paddr;
endmodule

// File: tb/tb_apb_prefetch_unit.sv
// Self-checking bench for apb_prefetch_unit: APB slave model with wait states and error
// injection, directed scenarios, and a randomized run against an expected-PC stream model.
module tb_apb_prefetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        err_o;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  apb_if apb();

  apb_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_apb(apb),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o),
    .err_o(err_o), .count_o(count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents are a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  int          fixed_wait = 0;
  bit          rand_wait  = 0;
  int          cur_wait   = 0;
  int          wait_cnt   = 0;
  bit          err_en     = 0;
  logic [31:0] err_addr   = 32'h0;

  assign apb.pready  = apb.psel && apb.penable && (wait_cnt >= cur_wait);
  assign apb.prdata  = (apb.psel && apb.penable) ? memf(apb.paddr) : 32'h0;
  assign apb.pslverr = apb.pready && err_en && (apb.paddr == err_addr);

  always @(posedge clk) begin
    if (apb.psel && !apb.penable) begin
      wait_cnt <= 0;
      cur_wait <= rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
    end else if (apb.psel && apb.penable && !apb.pready) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Bus monitor: SETUP addresses and completed transfers, with the cycle they happened in.
  logic [31:0] setup_q[$];
  logic [31:0] done_q[$];
  int          setup_cyc[$];
  int          done_cyc[$];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (apb.psel && !apb.penable) begin
      setup_q.push_back(apb.paddr);
      setup_cyc.push_back(cyc);
    end
    if (apb.psel && apb.penable && apb.pready) begin
      done_q.push_back(apb.paddr);
      done_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns at the negedge that begins cycle 0 after reset release.
  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_target_i = 32'h0;
    ready_i = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int dbase;
    logic [31:0] got;
    rst_n = 1'b0; ready_i = 1'b1; redirect_i = 1'b0; redirect_target_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({apb.psel, apb.penable, apb.paddr} !== 34'h0) begin
      errors++; $display("FAIL reset_apb: got %h expected 0", {apb.psel, apb.penable, apb.paddr});
    end
    checks++;
    if ({valid_o, pc_o, inst_o, err_o, count_o} !== 69'h0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b pc=%h inst=%h err=%b count=%0d expected all 0",
                         valid_o, pc_o, inst_o, err_o, count_o);
    end
    rst_n = 1'b1;
    dbase = done_q.size();
    checks++;
    if (apb.psel !== 1'b0) begin errors++; $display("FAIL cycle0_idle: psel=%b expected 0", apb.psel); end
    @(negedge clk);
    checks++;
    if ({apb.psel, apb.penable, apb.paddr} !== {2'b10, RPC}) begin
      errors++; $display("FAIL cycle1_setup: got psel=%b penable=%b paddr=%h expected 1 0 %h",
                         apb.psel, apb.penable, apb.paddr, RPC);
    end
    @(negedge clk);
    checks++;
    if ({apb.psel, apb.penable, apb.pready, apb.paddr} !== {3'b111, RPC}) begin
      errors++; $display("FAIL cycle2_access: got psel=%b penable=%b pready=%b paddr=%h expected 1 1 1 %h",
                         apb.psel, apb.penable, apb.pready, apb.paddr, RPC);
    end
    @(negedge clk);
    checks++;
    if ({valid_o, pc_o, inst_o} !== {1'b1, RPC, memf(RPC)}) begin
      errors++; $display("FAIL cycle3_valid: got valid=%b pc=%h inst=%h expected 1 %h %h",
                         valid_o, pc_o, inst_o, RPC, memf(RPC));
    end
    for (int i = 0; i < 20 && done_q.size() < dbase + 3; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      got = (done_q.size() > dbase + k) ? done_q[dbase + k] : 32'hDEAD_DEAD;
      checks++;
      if (got !== RPC + 32'(4 * k)) begin
        errors++; $display("FAIL paddr_seq[%0d]: got %h expected %h", k, got, RPC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_fill();
    int dbase, sbase;
    do_reset(1'b0);
    dbase = done_q.size();
    repeat (30) @(negedge clk);
    checks++;
    if (done_q.size() - dbase !== 4) begin
      errors++; $display("FAIL fill_transfers: got %0d expected 4", done_q.size() - dbase);
    end
    checks++;
    if ({count_o, apb.psel, pc_o} !== {3'd4, 1'b0, RPC}) begin
      errors++; $display("FAIL fill_state: got count=%0d psel=%b pc=%h expected 4 0 %h", count_o, apb.psel, pc_o, RPC);
    end
    sbase = setup_q.size();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (setup_q.size() - sbase !== 1) begin
      errors++; $display("FAIL one_pop_one_setup: got %0d setups expected 1", setup_q.size() - sbase);
    end else begin
      checks++;
      if (setup_q[sbase] !== RPC + 32'h10) begin
        errors++; $display("FAIL refill_addr: got %h expected %h", setup_q[sbase], RPC + 32'h10);
      end
    end
    checks++;
    if ({count_o, pc_o} !== {3'd4, RPC + 32'h4}) begin
      errors++; $display("FAIL refill_state: got count=%0d pc=%h expected 4 %h", count_o, pc_o, RPC + 32'h4);
    end
  endtask

  task automatic test_redirect_discard();
    int sbase, dbase, gap;
    fixed_wait = 3;
    do_reset(1'b1);
    sbase = setup_q.size();
    dbase = done_q.size();
    redirect_i = 1'b1; redirect_target_i = 32'h200;
    @(negedge clk);
    redirect_i = 1'b0;
    checks++;
    if ({apb.psel, apb.penable, apb.paddr} !== {2'b10, 32'h200}) begin
      errors++; $display("FAIL idle_redirect_setup: got psel=%b penable=%b paddr=%h expected 1 0 200",
                         apb.psel, apb.penable, apb.paddr);
    end
    @(negedge clk);
    redirect_i = 1'b1; redirect_target_i = 32'h403;
    @(negedge clk);
    redirect_i = 1'b0;
    for (int i = 0; i < 30 && !valid_o; i++) @(negedge clk);
    checks++;
    if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h400, memf(32'h400)}) begin
      errors++; $display("FAIL discard_first_entry: got valid=%b pc=%h inst=%h expected 1 400 %h",
                         valid_o, pc_o, inst_o, memf(32'h400));
    end
    checks++;
    if (setup_q.size() < sbase + 2 || done_q.size() < dbase + 1) begin
      errors++; $display("FAIL discard_bus: got %0d setups %0d dones expected >=2 >=1",
                         setup_q.size() - sbase, done_q.size() - dbase);
    end else begin
      checks++;
      if ({done_q[dbase], setup_q[sbase + 1]} !== {32'h200, 32'h400}) begin
        errors++; $display("FAIL discard_addrs: got done=%h next_setup=%h expected 200 400",
                           done_q[dbase], setup_q[sbase + 1]);
      end
      gap = setup_cyc[sbase + 1] - done_cyc[dbase];
      checks++;
      if (gap !== 1) begin errors++; $display("FAIL discard_gap: got %0d cycles expected 1", gap); end
    end
    fixed_wait = 0;
  endtask

  task automatic test_redirect_push_pop();
    bit found;
    int npop;
    logic [31:0] exp;
    do_reset(1'b0);
    repeat (8) @(negedge clk);
    ready_i = 1'b1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (apb.psel && apb.penable && apb.pready && valid_o) begin
        redirect_i = 1'b1; redirect_target_i = 32'h800; found = 1;
      end
      @(negedge clk);
    end
    redirect_i = 1'b0;
    checks++;
    if (!found) begin errors++; $display("FAIL pushpop_found: got 0 expected 1"); end
    checks++;
    if ({valid_o, count_o} !== 4'h0) begin
      errors++; $display("FAIL pushpop_flush: got valid=%b count=%0d expected 0 0", valid_o, count_o);
    end
    exp = 32'h800;
    npop = 0;
    for (int i = 0; i < 25; i++) begin
      if (valid_o && ready_i) begin
        checks++;
        if ({pc_o, inst_o} !== {exp, memf(exp)}) begin
          errors++; $display("FAIL pushpop_stream: got pc=%h inst=%h expected %h %h", pc_o, inst_o, exp, memf(exp));
        end
        exp += 32'd4; npop++;
      end
      @(negedge clk);
    end
    checks++;
    if (npop < 5) begin errors++; $display("FAIL pushpop_progress: got %0d pops expected >=5", npop); end
  endtask

  task automatic test_slverr();
    int sbase;
    logic [31:0] exp;
    err_en = 1; err_addr = 32'h10;
    do_reset(1'b0);
    sbase = setup_q.size();
    redirect_i = 1'b1; redirect_target_i = 32'h8;
    @(negedge clk);
    redirect_i = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if ({count_o, apb.psel} !== {3'd3, 1'b0} || setup_q.size() - sbase !== 3) begin
      errors++; $display("FAIL err_halt: got count=%0d psel=%b setups=%0d expected 3 0 3",
                         count_o, apb.psel, setup_q.size() - sbase);
    end
    ready_i = 1'b1;
    exp = 32'h8;
    for (int i = 0; i < 8; i++) begin
      if (valid_o && ready_i) begin
        checks++;
        if ({pc_o, inst_o, err_o} !== {exp, memf(exp), exp == 32'h10}) begin
          errors++; $display("FAIL err_entry: got pc=%h inst=%h err=%b expected %h %h %b",
                             pc_o, inst_o, err_o, exp, memf(exp), exp == 32'h10);
        end
        exp += 32'd4;
      end
      @(negedge clk);
    end
    checks++;
    if (exp !== 32'h14 || setup_q.size() - sbase !== 3) begin
      errors++; $display("FAIL err_no_fetch: got next_pc=%h setups=%0d expected 14 3", exp, setup_q.size() - sbase);
    end
    sbase = setup_q.size();
    redirect_i = 1'b1; redirect_target_i = 32'h20;
    @(negedge clk);
    redirect_i = 1'b0;
    for (int i = 0; i < 10 && !valid_o; i++) @(negedge clk);
    checks++;
    if ({valid_o, pc_o, err_o} !== {1'b1, 32'h20, 1'b0} || setup_q.size() <= sbase) begin
      errors++; $display("FAIL err_resume: got valid=%b pc=%h err=%b expected 1 20 0", valid_o, pc_o, err_o);
    end else begin
      checks++;
      if (setup_q[sbase] !== 32'h20) begin
        errors++; $display("FAIL err_resume_addr: got %h expected 20", setup_q[sbase]);
      end
    end
    err_en = 0;
  endtask

  task automatic test_wrap();
    int sbase;
    logic [31:0] exp;
    logic [31:0] want [3];
    do_reset(1'b1);
    sbase = setup_q.size();
    redirect_i = 1'b1; redirect_target_i = 32'hFFFF_FFFE;
    @(negedge clk);
    redirect_i = 1'b0;
    exp = 32'hFFFF_FFFC;
    for (int i = 0; i < 12; i++) begin
      if (valid_o && ready_i) begin
        checks++;
        if ({pc_o, inst_o} !== {exp, memf(exp)}) begin
          errors++; $display("FAIL wrap_stream: got pc=%h inst=%h expected %h %h", pc_o, inst_o, exp, memf(exp));
        end
        exp += 32'd4;
      end
      @(negedge clk);
    end
    want[0] = 32'hFFFF_FFFC; want[1] = 32'h0; want[2] = 32'h4;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (setup_q.size() <= sbase + k || setup_q[sbase + k] !== want[k]) begin
        errors++; $display("FAIL wrap_paddr[%0d]: got %h expected %h", k,
                           (setup_q.size() > sbase + k) ? setup_q[sbase + k] : 32'hDEAD_DEAD, want[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    for (int i = 0; i < 5 && !apb.psel; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({apb.psel, apb.penable, apb.paddr, valid_o, count_o} !== 38'h0) begin
      errors++; $display("FAIL async_reset: got psel=%b penable=%b paddr=%h valid=%b count=%0d expected 0",
                         apb.psel, apb.penable, apb.paddr, valid_o, count_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int npop;
    rand_wait = 1;
    do_reset(1'b0);
    exp = RPC;
    npop = 0;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (valid_o !== (count_o != 3'd0) || count_o > 3'd4 || (apb.psel && count_o >= 3'd4)) begin
        errors++; $display("FAIL rand_occupancy: got valid=%b count=%0d psel=%b expected count<=4, count<4 while psel",
                           valid_o, count_o, apb.psel);
      end
      if (!valid_o) begin
        checks++;
        if ({pc_o, inst_o, err_o} !== 65'h0) begin
          errors++; $display("FAIL rand_empty_head: got pc=%h inst=%h err=%b expected 0", pc_o, inst_o, err_o);
        end
      end
      ready_i = ($urandom_range(0, 9) < 7);
      redirect_i = ($urandom_range(0, 39) == 0);
      redirect_target_i = $urandom;
      if (redirect_i) begin
        exp = {redirect_target_i[31:2], 2'b00};
      end else if (valid_o && ready_i) begin
        checks++;
        if ({pc_o, inst_o, err_o} !== {exp, memf(exp), 1'b0}) begin
          errors++; $display("FAIL rand_stream: got pc=%h inst=%h err=%b expected %h %h 0",
                             pc_o, inst_o, err_o, exp, memf(exp));
        end
        exp += 32'd4;
        npop++;
      end
      @(negedge clk);
    end
    redirect_i = 1'b0;
    checks++;
    if (npop < 100) begin errors++; $display("FAIL rand_progress: got %0d pops expected >=100", npop); end
    rand_wait = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_redirect_discard();
    test_redirect_push_pop();
    test_slverr();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
